// File: rtl/proc_0_proc_0_cpu_mult_combine.sv
// Reduces the three partial products of the 16x16 multiplier cell to the low
// 32 bits of the 32x32 product through a two-entry valid/ready pipeline.
module proc_0_proc_0_cpu_mult_combine #(
    parameter int TAG_W            = 5,
    parameter bit RESULT_ZERO_FLAG = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      M_mul_cell_p1,
    input  logic [31:0]      M_mul_cell_p2,
    input  logic [31:0]      M_mul_cell_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    logic             valid_a;
    logic [31:0]      p1_a;
    logic [15:0]      cross_a;
    logic [TAG_W-1:0] tag_a;

    logic             valid_b;
    logic [31:0]      result_b;
    logic [TAG_W-1:0] tag_b;

    logic             adv_a;
    logic             adv_b;
    logic             accept;
    logic [31:0]      sum_a;
    logic             unused_hi;

    // Upper halves of the cross products only land above bit 31.
    assign unused_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

    assign adv_b    = ~valid_b | out_ready;
    assign adv_a    = valid_a & adv_b;
    assign in_ready = ~valid_a | adv_b;
    assign accept   = in_valid & in_ready & ~flush;
    assign sum_a    = p1_a + {cross_a, 16'h0000};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_a <= 1'b0;
            p1_a    <= '0;
            cross_a <= '0;
            tag_a   <= '0;
        end else begin
            if (flush)
                valid_a <= 1'b0;
            else if (accept)
                valid_a <= 1'b1;
            else if (adv_a)
                valid_a <= 1'b0;

            if (accept) begin
                p1_a    <= M_mul_cell_p1;
                cross_a <= M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
                tag_a   <= in_tag;
            end
        end
    end

    // A flush still lets an output handshake in the same cycle complete; only
    // the valid bits are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_b  <= 1'b0;
            result_b <= '0;
            tag_b    <= '0;
        end else begin
            if (flush)
                valid_b <= 1'b0;
            else if (adv_a)
                valid_b <= 1'b1;
            else if (out_ready)
                valid_b <= 1'b0;

            if (adv_a && !flush) begin
                result_b <= sum_a;
                tag_b    <= tag_a;
            end
        end
    end

    generate
        if (RESULT_ZERO_FLAG) begin : g_zero
            logic zero_b;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    zero_b <= 1'b0;
                else if (adv_a && !flush)
                    zero_b <= (sum_a == 32'h0000_0000);
            end

            assign out_zero = zero_b;
        end else begin : g_no_zero
            assign out_zero = 1'b0;
        end
    endgenerate

    assign out_valid  = valid_b;
    assign out_result = result_b;
    assign out_tag    = tag_b;

endmodule
